// File: rtl/game_stats.sv
// Score and lives bookkeeping: edge-detected hit events drive a saturating score,
// a lives count, a post-hit invulnerability window and the idle/play/over state.
module game_stats #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned POINTS        = 1,
  parameter int unsigned MAX_SCORE     = 99,
  parameter int unsigned INVULN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       start,
  input  logic       alien_hit,
  input  logic       player_hit,
  output logic [6:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       invuln
);

  localparam int unsigned CW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    INV,
    OVER
  } state_t;

  state_t          state;
  logic [CW-1:0]   inv_cnt;
  logic            start_q;
  logic            alien_q;
  logic            player_q;

  logic            start_ev;
  logic            alien_ev;
  logic            player_ev;
  logic [7:0]      score_sum;
  logic [6:0]      score_next;
  logic [1:0]      lives_dec;

  always_comb begin
    start_ev  = start & ~start_q;
    alien_ev  = alien_hit & ~alien_q;
    player_ev = player_hit & ~player_q;
  end

  // Sum is formed one bit wider than the score so the saturation compare never sees a wrap.
  always_comb begin
    score_sum  = {1'b0, score} + 8'(POINTS);
    score_next = (score_sum > 8'(MAX_SCORE)) ? 7'(MAX_SCORE) : score_sum[6:0];
    lives_dec  = lives - 2'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      score    <= '0;
      lives    <= 2'(START_LIVES);
      inv_cnt  <= '0;
      start_q  <= 1'b0;
      alien_q  <= 1'b0;
      player_q <= 1'b0;
    end else begin
      start_q  <= start;
      alien_q  <= alien_hit;
      player_q <= player_hit;

      // A new game overrides any hit edges arriving in the same cycle.
      if (start_ev) begin
        state   <= PLAY;
        score   <= '0;
        lives   <= 2'(START_LIVES);
        inv_cnt <= '0;
      end else begin
        case (state)
          PLAY: begin
            if (alien_ev)
              score <= score_next;
            if (player_ev && (lives != '0)) begin
              lives <= lives_dec;
              if (lives_dec == '0) begin
                state <= OVER;
              end else begin
                state   <= INV;
                inv_cnt <= CW'(INVULN_CYCLES - 1);
              end
            end
          end
          INV: begin
            if (alien_ev)
              score <= score_next;
            if (inv_cnt == '0)
              state <= PLAY;
            else
              inv_cnt <= inv_cnt - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign game_over = (state == OVER);
  assign invuln    = (state == INV);

endmodule

// File: tb/tb_game_stats.sv
// Directed bench for game_stats: two instances, one with default scoring and a
// short invulnerability window, one with POINTS=7 for the saturation case.
module tb_game_stats;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       s_a, ah_a, ph_a;
  logic       s_b, ah_b, ph_b;
  logic [6:0] score_a, score_b;
  logic [1:0] lives_a, lives_b;
  logic       go_a, go_b, inv_a, inv_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_stats #(
    .START_LIVES  (3),
    .POINTS       (1),
    .MAX_SCORE    (99),
    .INVULN_CYCLES(4)
  ) dut_a (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (s_a),
    .alien_hit (ah_a),
    .player_hit(ph_a),
    .score     (score_a),
    .lives     (lives_a),
    .game_over (go_a),
    .invuln    (inv_a)
  );

  game_stats #(
    .START_LIVES  (3),
    .POINTS       (7),
    .MAX_SCORE    (99),
    .INVULN_CYCLES(4)
  ) dut_b (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (s_b),
    .alien_hit (ah_b),
    .player_hit(ph_b),
    .score     (score_b),
    .lives     (lives_b),
    .game_over (go_b),
    .invuln    (inv_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n = 1'b0;
    s_a = 0; ah_a = 0; ph_a = 0;
    s_b = 0; ah_b = 0; ph_b = 0;
    step(2);
    chk("rst_score", score_a, 0);
    chk("rst_lives", lives_a, 3);
    chk("rst_go", go_a, 0);
    chk("rst_inv", inv_a, 0);
    chk("rst_score_b", score_b, 0);
    arst_n = 1'b1;
    step(1);

    // new game
    s_a = 1; step(1);
    chk("start_score", score_a, 0);
    chk("start_lives", lives_a, 3);
    chk("start_go", go_a, 0);
    s_a = 0; step(1);

    // five alien pulses, each held 3 cycles
    ah_a = 1; step(3);
    chk("held_once", score_a, 1);
    ah_a = 0; step(1);
    for (int i = 0; i < 4; i++) begin
      ah_a = 1; step(3);
      ah_a = 0; step(1);
    end
    chk("five_score", score_a, 5);
    chk("five_lives", lives_a, 3);
    chk("five_go", go_a, 0);

    // first player hit, E = entry edge
    ph_a = 1; step(1);
    chk("hit1_lives", lives_a, 2);
    chk("hit1_inv_e0", inv_a, 1);
    ph_a = 0; step(1);
    chk("hit1_inv_e1", inv_a, 1);
    ph_a = 1; step(1);
    chk("hit_in_inv_lives", lives_a, 2);
    chk("hit1_inv_e2", inv_a, 1);
    ph_a = 0; step(1);
    chk("hit1_inv_e3", inv_a, 1);
    ph_a = 1; step(1);
    chk("hit1_inv_e4", inv_a, 0);
    chk("hit_on_exit_lives", lives_a, 2);
    step(1);
    chk("held_hit_lives", lives_a, 2);
    chk("held_hit_inv", inv_a, 0);
    ph_a = 0; step(1);

    // second hit, alien counted during INV
    ph_a = 1; step(1);
    chk("hit2_lives", lives_a, 1);
    chk("hit2_inv", inv_a, 1);
    ph_a = 0; ah_a = 1; step(1);
    chk("alien_in_inv", score_a, 6);
    ah_a = 0; step(3);
    chk("hit2_inv_end", inv_a, 0);
    for (int i = 0; i < 4; i++) begin
      ah_a = 1; step(1);
      ah_a = 0; step(1);
    end
    chk("pre_sim_score", score_a, 10);

    // simultaneous alien + player on last life
    ah_a = 1; ph_a = 1; step(1);
    chk("sim_score", score_a, 11);
    chk("sim_lives", lives_a, 0);
    chk("sim_go", go_a, 1);
    chk("sim_inv", inv_a, 0);
    ah_a = 0; ph_a = 0; step(1);
    ah_a = 1; step(1);
    ah_a = 0; step(1);
    chk("over_frozen", score_a, 11);
    ph_a = 1; step(1);
    ph_a = 0; step(1);
    chk("over_lives", lives_a, 0);
    chk("over_go", go_a, 1);

    s_a = 1; step(1);
    chk("restart_score", score_a, 0);
    chk("restart_lives", lives_a, 3);
    chk("restart_go", go_a, 0);
    s_a = 0; step(1);

    // reset in the middle of INV, no clock edge needed
    ah_a = 1; step(1);
    ah_a = 0; step(1);
    chk("pre_rst_score", score_a, 1);
    ph_a = 1; step(1);
    chk("pre_rst_inv", inv_a, 1);
    ph_a = 0;
    #2 arst_n = 1'b0;
    #1;
    chk("async_score", score_a, 0);
    chk("async_lives", lives_a, 3);
    chk("async_inv", inv_a, 0);
    chk("async_go", go_a, 0);
    step(1);
    arst_n = 1'b1;
    ah_a = 1; step(1);
    ah_a = 0; step(1);
    ph_a = 1; step(1);
    ph_a = 0; step(1);
    chk("idle_score", score_a, 0);
    chk("idle_lives", lives_a, 3);
    chk("idle_inv", inv_a, 0);
    chk("idle_go", go_a, 0);

    // saturation with POINTS=7: 14 hits reach 98
    s_b = 1; step(1);
    s_b = 0; step(1);
    for (int i = 0; i < 14; i++) begin
      ah_b = 1; step(1);
      ah_b = 0; step(1);
    end
    chk("b_98", score_b, 98);
    ah_b = 1; step(1);
    chk("b_sat", score_b, 99);
    ah_b = 0; step(1);
    ah_b = 1; step(1);
    chk("b_sat_hold", score_b, 99);
    chk("b_lives", lives_b, 3);
    ah_b = 0; step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
